// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder: bus widths, the decoded
// bus codes carried on {read_write, write_commit}, the responder FSM
// state type and the default halt opcode.
package mem_responder_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned HALF_W = 6;

    localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'b0000;

    // {read_write, write_commit}
    localparam logic [1:0] BUS_READ         = 2'b10;
    localparam logic [1:0] BUS_STORE_ADDR   = 2'b00;
    localparam logic [1:0] BUS_STORE_COMMIT = 2'b01;
    localparam logic [1:0] BUS_HALT         = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_HELD = 2'd1,
        ST_HALTED    = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
// Pipeline-side bus of the memory responder plus the preload (prog) port.
//   master : the pipeline / boot loader (drives the bus and prog port)
//   slave  : mem_responder (returns read data and status flags)
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [ADDR_W-1:0] addr_data;
    logic              read_write;
    logic              write_commit;
    logic [DATA_W-1:0] mem_result;
    logic              prog_en;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              halted;
    logic              store_pending;
    logic              protocol_error;

    modport master (
        output addr_data, read_write, write_commit,
        output prog_en, prog_addr, prog_data,
        input  mem_result, halted, store_pending, protocol_error
    );

    modport slave (
        input  addr_data, read_write, write_commit,
        input  prog_en, prog_addr, prog_data,
        output mem_result, halted, store_pending, protocol_error
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array
// DEPTH x 12-bit word storage. Addresses wrap modulo DEPTH.
//   clk        : write clock
//   rd_addr    : combinational read address, rd_data the addressed word
//   wr_addr    : half-word write address
//   wr_lo_en   : write wr_half into bits [5:0]
//   wr_hi_en   : write wr_half into bits [11:6]
//   prog_*     : full-word preload write; wins over a half write to the
//                same word in the same cycle
// Contents have no reset and survive a responder reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_lo_en,
    input  logic              wr_hi_en,
    input  logic [HALF_W-1:0] wr_half,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [IDX_W-1:0] wrap(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) % DEPTH);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] prog_idx;
    logic             prog_hits_wr;

    assign rd_idx       = wrap(rd_addr);
    assign wr_idx       = wrap(wr_addr);
    assign prog_idx     = wrap(prog_addr);
    assign prog_hits_wr = prog_en && (prog_idx == wr_idx);

    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_lo_en && !prog_hits_wr) begin
            mem[wr_idx][HALF_W-1:0] <= wr_half;
        end
        if (wr_hi_en && !prog_hits_wr) begin
            mem[wr_idx][DATA_W-1:HALF_W] <= wr_half;
        end
        if (prog_en) begin
            mem[prog_idx] <= prog_data;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory responder for a small pipeline: zero-latency reads, two-phase
// half-word stores (address, then commit), sticky halt and protocol-error.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (array contents are kept)
//   bus   : mem_responder_if.slave -- shared addr/data bus, bus code,
//           read data, prog preload port and status flags
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | no store in progress
// ST_ADDR_HELD | store address latched, waiting for the commit phase
// ST_HALTED    | halt seen; bus ignored until reset, prog port still live
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] store_addr_q, store_addr_d;
    logic              perr_q, perr_d;
    logic              wr_lo_en, wr_hi_en;
    logic [1:0]        bus_code;
    logic [DATA_W-1:0] rd_data;

    // Halt is decoded from the bus code here; the opcode value is only
    // carried so the pipeline and responder share one parameter set.
    logic unused_halt_opcode;
    assign unused_halt_opcode = &{1'b0, HALT_OPCODE};

    assign bus_code = {bus.read_write, bus.write_commit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            store_addr_q <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_addr_q <= store_addr_d;
            perr_q       <= perr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        store_addr_d = store_addr_q;
        perr_d       = perr_q;
        wr_lo_en     = 1'b0;
        wr_hi_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (bus_code)
                    BUS_STORE_ADDR: begin
                        store_addr_d = bus.addr_data;
                        state_d      = ST_ADDR_HELD;
                    end
                    BUS_STORE_COMMIT: perr_d  = 1'b1;
                    BUS_HALT:         state_d = ST_HALTED;
                    default: ;
                endcase
            end
            ST_ADDR_HELD: begin
                case (bus_code)
                    BUS_STORE_ADDR: store_addr_d = bus.addr_data;
                    BUS_STORE_COMMIT: begin
                        // bit 6 selects which half the 6-bit payload lands in
                        wr_lo_en = !bus.addr_data[HALF_W];
                        wr_hi_en = bus.addr_data[HALF_W];
                        state_d  = ST_IDLE;
                    end
                    BUS_HALT: begin
                        store_addr_d = '0;
                        state_d      = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem_array (
        .clk       (clk),
        .rd_addr   (bus.addr_data),
        .rd_data   (rd_data),
        .wr_addr   (store_addr_q),
        .wr_lo_en  (wr_lo_en),
        .wr_hi_en  (wr_hi_en),
        .wr_half   (bus.addr_data[HALF_W-1:0]),
        .prog_en   (bus.prog_en),
        .prog_addr (bus.prog_addr),
        .prog_data (bus.prog_data)
    );

    assign bus.mem_result     = (state_q != ST_HALTED && bus_code == BUS_READ) ? rd_data : '0;
    assign bus.halted         = (state_q == ST_HALTED);
    assign bus.store_pending  = (state_q == ST_ADDR_HELD);
    assign bus.protocol_error = perr_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] SA = 2'b00;
    localparam logic [1:0] SC = 2'b01;
    localparam logic [1:0] HT = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // stimulus as driven (model reads these, never the DUT)
    logic        d_rw, d_wc, d_pe;
    logic [9:0]  d_ad, d_pa;
    logic [11:0] d_pd;

    // behavioural model
    logic [11:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_halted, m_pend, m_perr;
    int          m_saddr;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_halted = 0;
        m_pend   = 0;
        m_perr   = 0;
        m_saddr  = 0;
    endtask

    // What one rising edge does, from the bus-level rules.
    task automatic model_edge();
        int w;
        if (!m_halted) begin
            case ({d_rw, d_wc})
                SA: begin m_pend = 1; m_saddr = int'(d_ad) % DEPTH; end
                SC: begin
                    if (m_pend) begin
                        w = m_saddr;
                        if (d_ad[6]) m_mem[w] = {d_ad[5:0], m_mem[w][5:0]};
                        else         m_mem[w] = {m_mem[w][11:6], d_ad[5:0]};
                        m_pend = 0;
                    end else begin
                        m_perr = 1;
                    end
                end
                HT: begin m_halted = 1; m_pend = 0; end
                default: ;
            endcase
        end
        if (d_pe) begin
            w = int'(d_pa) % DEPTH;
            m_mem[w]   = d_pd;
            m_known[w] = 1;
        end
    endtask

    task automatic drive(input logic [1:0] code, input logic [9:0] ad,
                         input logic pe, input logic [9:0] pa, input logic [11:0] pd);
        d_rw = code[1]; d_wc = code[0]; d_ad = ad;
        d_pe = pe; d_pa = pa; d_pd = pd;
        bus.read_write   = d_rw;
        bus.write_commit = d_wc;
        bus.addr_data    = d_ad;
        bus.prog_en      = d_pe;
        bus.prog_addr    = d_pa;
        bus.prog_data    = d_pd;
    endtask

    task automatic step(input logic [1:0] code, input logic [9:0] ad,
                        input logic pe = 1'b0, input logic [9:0] pa = '0,
                        input logic [11:0] pd = '0);
        drive(code, ad, pe, pa, pd);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic prog(input logic [9:0] a, input logic [11:0] v);
        step(RD, 10'd0, 1'b1, a, v);
    endtask

    // Read with a hand-computed value: pins both the DUT and the model.
    task automatic read_lit(input logic [9:0] a, input logic [11:0] exp);
        drive(RD, a, 1'b0, '0, '0);
        @(negedge clk);
        chk("lit_read", bus.mem_result, exp);
        chk("lit_model", m_mem[int'(a)], exp);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(RD, 10'd0, 1'b0, '0, '0);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        chk("rst_perr", bus.protocol_error, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_pending", bus.store_pending, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [11:0] exp;
        bit          known;
        int          idx;
        if (run) begin
            chk("halted", bus.halted, m_halted);
            chk("store_pending", bus.store_pending, m_pend);
            chk("protocol_error", bus.protocol_error, m_perr);
            known = 1;
            exp   = '0;
            if (!m_halted && d_rw && !d_wc) begin
                idx   = int'(d_ad) % DEPTH;
                known = m_known[idx];
                exp   = m_mem[idx];
            end
            if (known) chk("mem_result", bus.mem_result, exp);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 0;
        end
        drive(RD, 10'd0, 1'b0, '0, '0);
        m_reset();
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // zero-latency read
        prog(10'd5, 12'hABC);
        read_lit(10'd5, 12'hABC);

        // low-half store
        prog(10'd7, 12'hFFF);
        step(SA, 10'd7);
        chk("pend_after_sa", bus.store_pending, 1'b1);
        step(SC, 10'h015);
        chk("pend_after_sc", bus.store_pending, 1'b0);
        read_lit(10'd7, 12'hFD5);

        // upper-half store with a read in between
        prog(10'd7, 12'h000);
        prog(10'd3, 12'h5A5);
        step(SA, 10'd7);
        step(RD, 10'd3);
        step(SC, 10'h04A);
        read_lit(10'd7, 12'h280);
        read_lit(10'd3, 12'h5A5);

        // commit with no pending address
        step(SC, 10'h03F);
        chk("perr_set", bus.protocol_error, 1'b1);
        step(RD, 10'd7);
        chk("perr_sticky", bus.protocol_error, 1'b1);
        read_lit(10'd7, 12'h280);
        do_reset();

        // prog beats commit to the same word
        prog(10'd2, 12'h777);
        step(SA, 10'd2);
        step(SC, 10'h04F, 1'b1, 10'd2, 12'h123);
        read_lit(10'd2, 12'h123);

        // prog to another word alongside a commit: both land
        step(SA, 10'd2);
        step(SC, 10'h00E, 1'b1, 10'd4, 12'h456);
        read_lit(10'd2, 12'h10E);
        read_lit(10'd4, 12'h456);

        // re-latch of the store address
        prog(10'd8, 12'h000);
        prog(10'd9, 12'h000);
        step(SA, 10'd8);
        step(SA, 10'd9);
        step(SA, 10'd9);
        step(SC, 10'h07F);
        read_lit(10'd9, 12'hFC0);
        read_lit(10'd8, 12'h000);

        // reset mid-store drops the address
        step(SA, 10'd5);
        do_reset();
        step(SC, 10'h011);
        chk("perr_after_rst", bus.protocol_error, 1'b1);
        read_lit(10'd5, 12'hABC);
        do_reset();

        // halt
        prog(10'd9, 12'h321);
        step(SA, 10'd9);
        step(HT, 10'd0);
        chk("halted_set", bus.halted, 1'b1);
        chk("halt_drops_pend", bus.store_pending, 1'b0);
        drive(RD, 10'd9, 1'b0, '0, '0);
        @(negedge clk);
        chk("halt_read_zero", bus.mem_result, 12'h000);
        @(posedge clk);
        model_edge();
        #1;
        step(SA, 10'd9);
        step(SC, 10'h015);
        step(RD, 10'd9, 1'b1, 10'd10, 12'h5AA);
        chk("halted_sticky", bus.halted, 1'b1);
        do_reset();
        read_lit(10'd9, 12'h321);
        read_lit(10'd10, 12'h5AA);
        step(RD, 10'd0);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
